e603_gnrl_sync_filt: RTL and testbench
======================================

Name: e603_gnrl_sync_filt

Overview:
Parametrised multi-channel input synchroniser for slow asynchronous level signals: external interrupts, GPIO, wake pins and straps.
- Each channel passes through a DP-deep flop chain, then a per-channel glitch filter with a runtime-programmable stability threshold.
- Each channel drives a filtered level plus single-cycle rise/fall pulses.
- Sits at the boundary between pad-side logic and core CSR/interrupt logic; successor to the plain DP-deep sync chain.

Parameters:
DP, 2, synchroniser depth in flops; legal range 2..4.
DW, 8, number of independent channels.
RST_VAL, {DW{1'b0}}, reset value of the sync chain and of dout, per channel.
FILT_EN, 1, 1 = glitch filter present; 0 = filter counters removed and threshold treated as 0.
FILT_W, 4, width of the per-channel filter counter and threshold.

Ports:
clk  input  1  core clock.
rst_n  input  1  reset, synchronous, active-low.
din_a  input  DW  asynchronous raw inputs, one bit per channel.
filt_thr  input  FILT_W  filter threshold, quasi-static from CSR, shared by all channels; ignored when FILT_EN=0.
dout  output  DW  synchronised, filtered level.
rise  output  DW  one-cycle pulse when dout[i] goes 0->1.
fall  output  DW  one-cycle pulse when dout[i] goes 1->0.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset (rst_n=0 sampled at a clk edge):
  - sync chain flops = RST_VAL; dout = RST_VAL.
  - all filter counters = 0; rise = fall = 0.
  - Reset asserted mid-operation aborts any pending filter count; no pulse is produced by reset entry or exit.
- Sync chain: stage0 <= din_a; stage k <= stage k-1. s[i] = stage DP-1 bit i. No logic between stages.
- Filter, per channel i, at each clk edge out of reset:
  - s[i] == dout[i]: cnt[i] <= 0; dout unchanged.
  - s[i] != dout[i] and cnt[i] >= filt_thr: dout[i] <= s[i]; cnt[i] <= 0.
  - s[i] != dout[i] and cnt[i] < filt_thr: cnt[i] <= cnt[i] + 1; dout unchanged.
  - The compare is >=, so lowering filt_thr below an in-flight count commits on the next edge. Raising it extends the wait.
  - The counter never exceeds filt_thr, so no wrap is possible.
  - A glitch of at most filt_thr cycles at s resets the counter when s returns and produces no dout change.
- Latency: a clean level change on din_a set up before edge E0 appears on dout after edge E0+DP+filt_thr.
  - filt_thr=0 gives DP+1 cycles; this is identical to FILT_EN=0.
- Edges:
  - rise[i] and fall[i] are registered and asserted in exactly the cycle in which dout[i] holds its new value. They are deasserted the next cycle.
  - rise[i] and fall[i] are never both 1.
  - With filt_thr=0 and a toggling s, dout can change every cycle; rise and fall then alternate cycle by cycle.
- Channels are fully independent: simultaneous changes on several channels give simultaneous pulses.
- FILT_EN=0: no counters are instantiated; dout[i] <= s[i] every edge.
- All flops are plain synchronous-reset flops. Only stage 0 samples asynchronous data; downstream timing treats it as a CDC endpoint.

Decomposition:
- Shared package holds:
  - E603_SYNC_DP_MIN=2 and E603_SYNC_DP_MAX=4, with an elaboration check on DP.
  - Default FILT_W.
  - RST_VAL helper constant for all-zero channels.
- Sub-module e603_gnrl_sync_filt_ch: one channel (counter, compare, dout, rise/fall flops) with parameters FILT_EN, FILT_W and RST_BIT.
- The top level holds the DW-wide DP-stage chain and a generate loop over DW channel instances.

Test Plan:
1. Reset: din_a=8'hFF held with rst_n=0 for 5 cycles -> dout=8'h00, rise=fall=0 throughout. After release with DP=2, filt_thr=3: dout=8'hFF after 2+3+1 edges, rise=8'hFF for exactly one cycle, no fall.
2. Glitch rejection: filt_thr=4, din_a[0] pulses 1 for 3 cycles -> dout[0] stays 0, no rise. A 6-cycle pulse -> dout[0] rises on edge DP+4 after the input edge and falls symmetrically after release.
3. Threshold zero / toggle: filt_thr=0, din_a[3] toggles every cycle -> dout[3] follows with DP+1 latency. rise[3] and fall[3] alternate every cycle and never overlap.
4. Threshold change mid-count: filt_thr=10, change din_a[1]; after cnt reaches 5 write filt_thr=2 -> dout[1] commits on the next edge, one rise pulse.
5. Reset mid-operation: during a pending count on channel 2, pulse rst_n=0 for 1 cycle -> cnt=0, dout[2]=RST_VAL, no pulse. The full DP+filt_thr+1 wait restarts after release.
6. FILT_EN=0, DP=3, DW=1, RST_VAL=1: din_a falls -> dout falls after exactly 4 edges with one fall pulse; filt_thr ignored (drive 15).

Source files
------------

// File: rtl/e603_gnrl_sync_filt_pkg.sv
// ----------------------------------------------------------------------------
// e603_gnrl_sync_filt_pkg
//   Shared constants and types for the multi-channel input synchroniser with
//   glitch filter.
//   - E603_SYNC_DP_MIN / E603_SYNC_DP_MAX : legal synchroniser depth range.
//   - E603_SYNC_FILT_W_DEF                : default filter counter width.
//   - E603_SYNC_RST_LOW                   : per-channel reset level used to
//                                           build an all-zero RST_VAL.
//   - e603_filt_act_e                     : per-edge filter decision.
// ----------------------------------------------------------------------------
package e603_gnrl_sync_filt_pkg;

  localparam int E603_SYNC_DP_MIN     = 2;
  localparam int E603_SYNC_DP_MAX     = 4;
  localparam int E603_SYNC_FILT_W_DEF = 4;

  // Replicate this bit DW times for the usual "all channels reset low" value.
  localparam logic E603_SYNC_RST_LOW = 1'b0;

  // What the filter does with one channel at one clock edge.
  typedef enum logic [1:0] {
    FILT_ACT_HOLD   = 2'd0,  // synced input agrees with output, clear count
    FILT_ACT_COUNT  = 2'd1,  // disagreement still inside the threshold window
    FILT_ACT_COMMIT = 2'd2   // disagreement stable long enough, take new level
  } e603_filt_act_e;

  // True when a depth value can be built by the top level.
  function automatic bit e603_sync_dp_legal(input int dp);
    return (dp >= E603_SYNC_DP_MIN) && (dp <= E603_SYNC_DP_MAX);
  endfunction

endpackage

// File: rtl/e603_gnrl_sync_filt_ch.sv
// ----------------------------------------------------------------------------
// e603_gnrl_sync_filt_ch
//   One channel of the synchroniser: glitch filter counter, threshold
//   compare, filtered output level and registered edge pulses.
//   Ports:
//     clk      : core clock
//     rst_n    : synchronous active-low reset
//     s        : already-synchronised input level for this channel
//     filt_thr : shared stability threshold (unused when FILT_EN=0)
//     dout     : filtered level
//     rise     : one-cycle pulse in the first cycle dout is 1 after being 0
//     fall     : one-cycle pulse in the first cycle dout is 0 after being 1
// ----------------------------------------------------------------------------
module e603_gnrl_sync_filt_ch
  import e603_gnrl_sync_filt_pkg::*;
#(
  parameter int   FILT_EN = 1,
  parameter int   FILT_W  = E603_SYNC_FILT_W_DEF,
  parameter logic RST_BIT = E603_SYNC_RST_LOW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s,
  input  logic [FILT_W-1:0] filt_thr,
  output logic              dout,
  output logic              rise,
  output logic              fall
);

  logic commit;

  if (FILT_EN != 0) begin : g_filt
    logic [FILT_W-1:0] cnt;
    logic [FILT_W-1:0] cnt_next;
    e603_filt_act_e    act;

    // The counter only advances while cnt < filt_thr, so it is bounded by
    // the threshold and cannot wrap. Using >= means a threshold lowered
    // below an in-flight count commits on the very next edge.
    always_comb begin
      act      = FILT_ACT_HOLD;
      cnt_next = '0;
      if (s != dout) begin
        if (cnt >= filt_thr) begin
          act = FILT_ACT_COMMIT;
        end else begin
          act      = FILT_ACT_COUNT;
          cnt_next = cnt + 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt <= '0;
      end else begin
        cnt <= cnt_next;
      end
    end

    assign commit = (act == FILT_ACT_COMMIT);
  end else begin : g_nofilt
    // No filtering: behaves exactly like a threshold of zero.
    logic unused_thr;
    assign unused_thr = ^filt_thr;
    assign commit     = (s != dout);
  end

  // Pulses are registered alongside dout so they line up with the cycle in
  // which dout first shows its new value. Reset never creates a pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout <= RST_BIT;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      if (commit) begin
        dout <= s;
      end
      rise <= commit &  s;
      fall <= commit & ~s;
    end
  end

endmodule

// File: rtl/e603_gnrl_sync_filt.sv
// ----------------------------------------------------------------------------
// e603_gnrl_sync_filt
//   Multi-channel synchroniser for slow asynchronous level inputs (interrupts,
//   GPIO, wake pins, straps). Each channel goes through a DP-deep flop chain
//   and then a per-channel glitch filter with a shared runtime threshold.
//   Ports:
//     clk      : core clock
//     rst_n    : synchronous active-low reset
//     din_a    : asynchronous raw inputs, one bit per channel
//     filt_thr : filter threshold, quasi-static, shared by all channels
//     dout     : synchronised, filtered levels
//     rise     : one-cycle pulse per channel on dout 0->1
//     fall     : one-cycle pulse per channel on dout 1->0
// ----------------------------------------------------------------------------
module e603_gnrl_sync_filt
  import e603_gnrl_sync_filt_pkg::*;
#(
  parameter int            DP      = 2,
  parameter int            DW      = 8,
  parameter logic [DW-1:0] RST_VAL = {DW{E603_SYNC_RST_LOW}},
  parameter int            FILT_EN = 1,
  parameter int            FILT_W  = E603_SYNC_FILT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DW-1:0]     din_a,
  input  logic [FILT_W-1:0] filt_thr,
  output logic [DW-1:0]     dout,
  output logic [DW-1:0]     rise,
  output logic [DW-1:0]     fall
);

  if (!e603_sync_dp_legal(DP)) begin : g_bad_dp
    $error("e603_gnrl_sync_filt: DP=%0d outside legal range %0d..%0d",
           DP, E603_SYNC_DP_MIN, E603_SYNC_DP_MAX);
  end

  // Plain flop chain with nothing between stages; stage[0] is the only
  // flop that samples asynchronous data and is the CDC endpoint.
  logic [DW-1:0] stage [DP];
  logic [DW-1:0] s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < DP; k++) begin
        stage[k] <= RST_VAL;
      end
    end else begin
      stage[0] <= din_a;
      for (int k = 1; k < DP; k++) begin
        stage[k] <= stage[k-1];
      end
    end
  end

  assign s = stage[DP-1];

  for (genvar gi = 0; gi < DW; gi++) begin : g_ch
    e603_gnrl_sync_filt_ch #(
      .FILT_EN (FILT_EN),
      .FILT_W  (FILT_W),
      .RST_BIT (RST_VAL[gi])
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .s        (s[gi]),
      .filt_thr (filt_thr),
      .dout     (dout[gi]),
      .rise     (rise[gi]),
      .fall     (fall[gi])
    );
  end

endmodule

// File: tb/tb_e603_gnrl_sync_filt.sv
// ----------------------------------------------------------------------------
// tb_e603_gnrl_sync_filt
//   Directed and randomised checks of e603_gnrl_sync_filt against a cycle
//   model built from the filtering rules, plus a second instance with the
//   filter removed, DP=3, one channel reset high.
// ----------------------------------------------------------------------------
module tb_e603_gnrl_sync_filt;

  localparam int DP = 2;
  localparam int DW = 8;
  localparam int FW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] din_a;
  logic [FW-1:0] filt_thr;
  logic [DW-1:0] dout, rise, fall;

  logic          din_b;
  logic [FW-1:0] thr_b;
  logic          dout_b, rise_b, fall_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  e603_gnrl_sync_filt #(
    .DP (DP), .DW (DW), .RST_VAL ('0), .FILT_EN (1), .FILT_W (FW)
  ) dut (
    .clk (clk), .rst_n (rst_n), .din_a (din_a), .filt_thr (filt_thr),
    .dout (dout), .rise (rise), .fall (fall)
  );

  e603_gnrl_sync_filt #(
    .DP (3), .DW (1), .RST_VAL (1'b1), .FILT_EN (0), .FILT_W (FW)
  ) dut_b (
    .clk (clk), .rst_n (rst_n), .din_a (din_b), .filt_thr (thr_b),
    .dout (dout_b), .rise (rise_b), .fall (fall_b)
  );

  // Reference model: history of sampled inputs, and per channel the number
  // of consecutive edges the synced level has disagreed with the output.
  logic [DW-1:0] hist [DP];
  logic [DW-1:0] dout_m = '0;
  logic [DW-1:0] rise_m = '0;
  logic [DW-1:0] fall_m = '0;
  int            run_m [DW];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [DW-1:0] s_m;
    if (!rst_n) begin
      for (int k = 0; k < DP; k++) hist[k] = '0;
      dout_m = '0;
      rise_m = '0;
      fall_m = '0;
      for (int i = 0; i < DW; i++) run_m[i] = 0;
    end else begin
      s_m = hist[DP-1];
      for (int k = DP-1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = din_a;
      rise_m = '0;
      fall_m = '0;
      for (int i = 0; i < DW; i++) begin
        if (s_m[i] == dout_m[i]) begin
          run_m[i] = 0;
        end else if (run_m[i] >= int'(filt_thr)) begin
          dout_m[i] = s_m[i];
          run_m[i]  = 0;
          if (s_m[i]) rise_m[i] = 1'b1;
          else        fall_m[i] = 1'b1;
        end else begin
          run_m[i] = run_m[i] + 1;
        end
      end
    end
  endtask

  // One clock edge: advance the model with the inputs the DUT sampled,
  // then compare all outputs shortly after the edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("dout", 32'(dout), 32'(dout_m));
    check("rise", 32'(rise), 32'(rise_m));
    check("fall", 32'(fall), 32'(fall_m));
    check("rise_and_fall", 32'(rise & fall), 32'h0);
  endtask

  initial begin
    int rise_at, fall_at, hit, pulses;
    logic seen;

    rst_n    = 1'b0;
    din_a    = 8'hFF;
    filt_thr = 4'd3;
    din_b    = 1'b1;
    thr_b    = 4'hF;

    // 1. Reset held with inputs high, then release with filt_thr=3.
    for (int c = 0; c < 5; c++) begin
      step();
      check("rst_dout", 32'(dout), 32'h00);
      check("rst_pulses", 32'(rise | fall), 32'h00);
      check("rst_dout_b", 32'(dout_b), 32'h1);
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step();
      if (e == 5) check("t1_dout_before", 32'(dout), 32'h00);
    end
    check("t1_dout", 32'(dout), 32'hFF);
    check("t1_rise", 32'(rise), 32'hFF);
    step();
    check("t1_rise_once", 32'(rise), 32'h00);
    check("t1_no_fall", 32'(fall), 32'h00);
    $display("txn reset_release dout=%0h", dout);

    // 2. Glitch rejection with filt_thr=4.
    filt_thr = 4'd4;
    din_a    = 8'h00;
    repeat (10) step();
    check("t2_settle", 32'(dout), 32'h00);
    seen = 1'b0;
    din_a[0] = 1'b1;
    repeat (3) step();
    din_a[0] = 1'b0;
    for (int e = 0; e < 10; e++) begin
      step();
      seen = seen | rise[0] | dout[0];
    end
    check("t2_glitch", 32'(seen), 32'h0);
    rise_at = -1;
    fall_at = -1;
    din_a[0] = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      if (e == 7) din_a[0] = 1'b0;
      step();
      if (rise[0] && rise_at < 0) rise_at = e;
      if (fall[0] && fall_at < 0) fall_at = e;
    end
    check("t2_rise_edge", 32'(rise_at), 32'd7);
    check("t2_fall_edge", 32'(fall_at), 32'd13);
    $display("txn glitch rise_at=%0d fall_at=%0d", rise_at, fall_at);

    // 3. Threshold zero, channel 3 toggling every cycle.
    filt_thr = 4'd0;
    for (int e = 1; e <= 12; e++) begin
      din_a[3] = ~din_a[3];
      step();
      if (e >= DP + 1) begin
        check("t3_rise_alt", 32'(rise[3]), 32'(e % 2));
        check("t3_one_pulse", 32'(rise[3] ^ fall[3]), 32'h1);
      end
    end
    repeat (4) step();
    $display("txn toggle dout=%0h", dout);

    // 4. Threshold lowered while channel 1 is counting.
    filt_thr = 4'd10;
    din_a[1] = 1'b1;
    repeat (7) step();
    check("t4_pending", 32'(dout[1]), 32'h0);
    filt_thr = 4'd2;
    step();
    check("t4_commit", 32'(dout[1]), 32'h1);
    check("t4_rise", 32'(rise[1]), 32'h1);
    step();
    check("t4_rise_once", 32'(rise[1]), 32'h0);
    $display("txn thr_change dout=%0h", dout);

    // 5. Reset pulse in the middle of a count on channel 2.
    filt_thr = 4'd3;
    din_a[2] = 1'b1;
    repeat (3) step();
    rst_n = 1'b0;
    step();
    check("t5_rst_dout", 32'(dout), 32'h00);
    check("t5_rst_pulse", 32'(rise | fall), 32'h00);
    rst_n = 1'b1;
    hit    = -1;
    pulses = 0;
    for (int e = 1; e <= 15; e++) begin
      step();
      if (e == 1) pulses = pulses + int'(rise != 0) + int'(fall != 0);
      if (dout[2] && hit < 0) hit = e;
    end
    check("t5_exit_pulse", 32'(pulses), 32'd0);
    check("t5_restart", 32'(hit), 32'd6);
    $display("txn reset_mid dout2_at=%0d", hit);

    // 6. Unfiltered instance: DP=3, falls after 4 edges, threshold ignored.
    check("t6_init", 32'(dout_b), 32'h1);
    din_b   = 1'b0;
    fall_at = -1;
    for (int e = 1; e <= 10; e++) begin
      step();
      check("t6_no_rise", 32'(rise_b), 32'h0);
      if (!dout_b && fall_at < 0) begin
        fall_at = e;
        check("t6_fall_pulse", 32'(fall_b), 32'h1);
      end else begin
        check("t6_fall_quiet", 32'(fall_b), 32'h0);
      end
    end
    check("t6_latency", 32'(fall_at), 32'd4);
    $display("txn nofilt fall_at=%0d", fall_at);

    // Randomised traffic against the model.
    for (int c = 0; c < 400; c++) begin
      if (c % 50 == 0) filt_thr = FW'($urandom_range(0, 6));
      din_a = din_a ^ DW'($urandom & $urandom & $urandom);
      rst_n = (c != 217);
      step();
    end
    rst_n = 1'b1;
    $display("txn random cycles=400 dout=%0h", dout);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
